// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 decryption datapath.
package aes_dec_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  localparam logic [2:0]  SEL_IDLE = 3'b100;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Column 0 sits in the most significant word.
  function automatic word_t get_col(input state_t s, input logic [1:0] idx);
    word_t w;
    unique case (idx)
      2'd0:    w = s[127:96];
      2'd1:    w = s[95:64];
      2'd2:    w = s[63:32];
      default: w = s[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inv_mix_col.sv
// Combinational InvMixColumns of a single 32-bit state column (row 0 in bits [31:24]).
module inv_mix_col
  import aes_dec_pkg::*;
(
  input  word_t col_i,
  output word_t col_o
);

  logic [7:0] a [4];
  logic [7:0] b [4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a[r] = col_i[31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      b[r] = gf_mul14(a[r]) ^ gf_mul11(a[(r+1)%4]) ^ gf_mul13(a[(r+2)%4]) ^
             gf_mul9(a[(r+3)%4]);
    end
  end

  assign col_o = {b[0], b[1], b[2], b[3]};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial InvMixColumns engine: one column per cycle, in-place write-back,
// Start/Done handshake and a held 128-bit result.
module inv_mix_columns_seq
  import aes_dec_pkg::*;
#(
  parameter int unsigned STAGE_REG = 0,
  parameter int unsigned COL_W     = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [127:0]     State_In,
  output logic             Busy,
  output logic             Done,
  output logic [COL_W-1:0] Col_Out,
  output logic [2:0]       Col_Sel,
  output logic [127:0]     State_Out
);

  fsm_e       state_q, state_d;
  state_t     work_q, work_d;
  state_t     state_out_q, state_out_d;
  logic [2:0] cnt_q, cnt_d;

  logic       comp_en;
  word_t      mix_in, mix_out;
  logic       wb_vld;
  logic [1:0] wb_idx;
  word_t      wb_col;

  // Counter reaching 4 marks all columns issued; with the stage register the
  // last write-back still follows one cycle later.
  assign comp_en = (state_q == StRun) && !cnt_q[2];
  assign mix_in  = get_col(work_q, cnt_q[1:0]);

  inv_mix_col u_inv_mix_col (
    .col_i (mix_in),
    .col_o (mix_out)
  );

  if (STAGE_REG != 0) begin : g_stage
    logic       pipe_vld_q;
    logic [1:0] pipe_idx_q;
    word_t      pipe_col_q;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        pipe_vld_q <= 1'b0;
        pipe_idx_q <= 2'd0;
        pipe_col_q <= '0;
      end else begin
        pipe_vld_q <= comp_en;
        pipe_idx_q <= cnt_q[1:0];
        pipe_col_q <= comp_en ? mix_out : '0;
      end
    end

    assign wb_vld = pipe_vld_q;
    assign wb_idx = pipe_idx_q;
    assign wb_col = pipe_col_q;
  end else begin : g_comb
    assign wb_vld = comp_en;
    assign wb_idx = cnt_q[1:0];
    assign wb_col = mix_out;
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    state_out_d = state_out_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          work_d  = State_In;
          cnt_d   = 3'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (comp_en) begin
          cnt_d = cnt_q + 3'd1;
        end
        for (int c = 0; c < NUM_COLS; c++) begin
          if (wb_vld && (wb_idx == c[1:0])) begin
            work_d[127-32*c -: 32] = wb_col;
          end
        end
        if (wb_vld && (wb_idx == 2'd3)) begin
          state_d     = StDone;
          state_out_d = work_d;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      work_q      <= '0;
      cnt_q       <= 3'd0;
      state_out_q <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      state_out_q <= state_out_d;
    end
  end

  assign Busy      = (state_q == StRun);
  assign Done      = (state_q == StDone);
  assign Col_Out   = wb_vld ? wb_col : '0;
  assign Col_Sel   = wb_vld ? {1'b0, wb_idx} : SEL_IDLE;
  assign State_Out = state_out_q;

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Sequential InvMixColumns engine for the AES-128 decryption datapath. It processes one 32-bit state column per cycle and presents each result as a column word plus a column select to the downstream column-replacement selector. It also assembles and holds the full 128-bit InvMixColumns result for the decryption control FSM. Start/Done handshake with the round controller.

Parameters:
STAGE_REG, 0, 1 inserts a register between column compute and output/write-back (+1 cycle latency); 0 is purely combinational per column.
COL_W, 32, column width in bits; fixed at 32 for AES, no other value supported.

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only in IDLE
State_In  input  128  state to transform; column 0 = [127:96], column 3 = [31:0]
Busy  output  1  high in RUN
Done  output  1  single-cycle pulse, result valid
Col_Out  output  32  InvMixColumns of current column (selector col_in)
Col_Sel  output  3  column index 3'b000..3'b011 of Col_Out; 3'b100 when no valid column
State_Out  output  128  assembled result; held from Done until next Start

Behaviour:
- Interface fixed: one clock Clk; Reset is synchronous and active-high.
- Reset values: Busy=0, Done=0, Col_Out=0, Col_Sel=3'b100, State_Out=0, FSM=IDLE, counter=0, pipeline valid=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: Start=1 at an edge latches State_In into the working register, clears counter, goes to RUN. Start=0 stays in IDLE.
- RUN: in each cycle, compute column counter idx from the working register via inv_mix_col. Write the result back into the same column slot at the edge, then increment the counter.
- STAGE_REG=0:
  - Col_Out/Col_Sel are combinational from the current idx.
  - Start sampled in cycle N gives RUN in cycles N+1..N+4 with Col_Sel 0,1,2,3.
  - DONE in cycle N+5.
- STAGE_REG=1:
  - Compute runs in N+1..N+4. Registered Col_Out/Col_Sel are valid in N+2..N+5.
  - Write-back uses the registered value, so RUN spans N+1..N+5.
  - DONE in cycle N+6.
- DONE: Done=1 for exactly one cycle. State_Out = working register. Return to IDLE unconditionally.
- Start is ignored in RUN and DONE. It is not queued; the requester must re-assert it in IDLE.
- Col_Sel=3'b100 and Col_Out=0 in IDLE, DONE, and the STAGE_REG=1 fill cycle. The downstream selector therefore sees its default case.
- State_Out updates only at the DONE transition. It is stable at all other times, including during the next RUN until that run completes.
- Reset during RUN: abort immediately, discard partial results, apply all reset values.
- Reset and Start in the same cycle: Reset wins; the block stays in IDLE.
- Arithmetic, GF(2^8) with reduction polynomial 0x11B:
  - Row 0 is column bits [31:24].
  - Output row r = 0E·a[r] ^ 0B·a[r+1] ^ 0D·a[r+2] ^ 09·a[r+3], indices mod 4.
  - Multiplies are built from the xtime chain: 09=x8^x1, 0B=x8^x2^x1, 0D=x8^x4^x1, 0E=x8^x4^x2.

Decomposition:
- Shared package aes_dec_pkg:
  - word_t (logic [31:0]) and state_t (logic [127:0]).
  - SEL_IDLE = 3'b100 and NUM_COLS = 4.
  - Functions xtime(byte) and gf_mul9/11/13/14.
- Sub-module inv_mix_col: combinational, one 32-bit column in and one out; instantiated once. Reused by any unrolled variant later.

Test Plan:
- Single column vectors, STAGE_REG=0: State_In = 8e4da1bc_9fdc589d_01010101_d5d5d7d6, Start one cycle.
  - Col_Out sequence db135345, f20a225c, 01010101, d4d4d4d5 with Col_Sel 0..3.
  - Done at N+5; State_Out = db135345_f20a225c_01010101_d4d4d4d5.
- Same stimulus, STAGE_REG=1: identical Col_Out/Col_Sel sequence shifted one cycle. Done at N+6; same State_Out.
- Identity columns: State_In = {4{c6c6c6c6}} -> State_Out = {4{c6c6c6c6}}; Busy high exactly 4 cycles (STAGE_REG=0).
- Start held high continuously: exactly one run per IDLE entry. Second run starts the cycle after DONE; Start during RUN/DONE causes no restart and no State_Out change mid-run.
- Reset asserted in RUN after column 1: next cycle Busy=0, Col_Sel=3'b100, State_Out=0, Done never pulses. A fresh Start then completes normally with the correct result.
- Round trip: State_In = 4d7ebdf8 in all columns -> every column of State_Out = 2d26314c. Col_Sel is never outside 0..3 or 3'b100 at any time.
